// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (CPU, DMA) and the memory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic [1:0]        arb_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output stall, arb_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  stall, arb_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer sharing one memory between CPU and DMA ports.
// Define MEM_ARB_FAIR_EN to add the DMA starvation guard; default is strict CPU priority.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic          CLK,
  input logic          Reset,
  mem_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | sample requests, latch grant and requester fields
  // ACCESS | drive memory for WAIT_CYCLES+1 cycles
  // DONE   | one-cycle ack to the granted port
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  logic [1:0]        state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              gnt_dma;
  logic              lat_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              any_req;
  logic              pick_dma;
  logic              force_dma;
  logic              last_cyc;
  logic              mem_re_c, mem_we_c, cpu_ack_c, dma_ack_c;

  assign any_req  = bus.cpu_req | bus.dma_req;
  assign pick_dma = bus.dma_req & (~bus.cpu_req | force_dma);
  assign last_cyc = (wait_cnt == LAST_CNT);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wait_cnt    <= '0;
      gnt_dma     <= 1'b0;
      lat_we      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_dma  <= pick_dma;
        wait_cnt <= '0;
        addr_q   <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
        wdata_q  <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
        lat_we   <= pick_dma ? bus.dma_we    : bus.cpu_we;
      end
      if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
        if (last_cyc && !lat_we) begin
          if (gnt_dma) dma_rdata_q <= bus.mem_rdata;
          else         cpu_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // Counts CPU grants that beat a waiting DMA; once saturated, the next such
  // grant arms dma_due so the following arbitration goes to DMA.
  logic [1:0] starv_cnt;
  logic       dma_due;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      starv_cnt <= '0;
      dma_due   <= 1'b0;
    end else if (state == IDLE && any_req) begin
      if (pick_dma || !bus.dma_req) begin
        starv_cnt <= '0;
        dma_due   <= 1'b0;
      end else if (starv_cnt == 2'd3) begin
        dma_due   <= 1'b1;
      end else begin
        starv_cnt <= starv_cnt + 2'd1;
      end
    end
  end

  assign force_dma = dma_due;
`else
  assign force_dma = 1'b0;
`endif

  always_comb begin
    mem_re_c  = 1'b0;
    mem_we_c  = 1'b0;
    cpu_ack_c = 1'b0;
    dma_ack_c = 1'b0;
    case (state)
      ACCESS: begin
        mem_re_c = ~lat_we;
        mem_we_c = lat_we & last_cyc;
      end
      DONE: begin
        cpu_ack_c = ~gnt_dma;
        dma_ack_c = gnt_dma;
      end
      default: ;
    endcase
  end

  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.cpu_ack   = cpu_ack_c;
  assign bus.dma_ack   = dma_ack_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.stall     = bus.cpu_req & ~cpu_ack_c;
  assign bus.arb_state = state;
endmodule
